// File: rtl/operand_fetch_if.sv
// Bundle of decode, register-file, writeback and execute-side signals of the operand-fetch stage.
interface operand_fetch_if #(
  parameter int unsigned REGS_PTR_W = 5,
  parameter int unsigned REGS_NUM   = 32,
  parameter int unsigned REG_SIZE   = 32
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [REGS_PTR_W-1:0] in_rs1;
  logic [REGS_PTR_W-1:0] in_rs2;
  logic [REGS_PTR_W-1:0] in_rd;
  logic                  in_rd_we;

  logic [REGS_PTR_W-1:0] rf_rs1;
  logic [REGS_PTR_W-1:0] rf_rs2;
  logic [REG_SIZE-1:0]   rf_rd1;
  logic [REG_SIZE-1:0]   rf_rd2;
  logic                  rf_we;
  logic [REGS_PTR_W-1:0] rf_wa;
  logic [REG_SIZE-1:0]   rf_wd;

  logic                  wb_vld;
  logic [REGS_PTR_W-1:0] wb_rd;
  logic [REG_SIZE-1:0]   wb_data;

  logic                  out_vld;
  logic                  out_rdy;
  logic [REG_SIZE-1:0]   out_op1;
  logic [REG_SIZE-1:0]   out_op2;
  logic [REGS_PTR_W-1:0] out_rd;
  logic                  out_rd_we;

  logic [REGS_NUM-1:0]   sb_pend;

  modport slave (
    input  in_vld, in_rs1, in_rs2, in_rd, in_rd_we,
    input  rf_rd1, rf_rd2,
    input  wb_vld, wb_rd, wb_data,
    input  out_rdy,
    output in_rdy, rf_rs1, rf_rs2, rf_we, rf_wa, rf_wd,
    output out_vld, out_op1, out_op2, out_rd, out_rd_we, sb_pend
  );

  modport master (
    output in_vld, in_rs1, in_rs2, in_rd, in_rd_we,
    output rf_rd1, rf_rd2,
    output wb_vld, wb_rd, wb_data,
    output out_rdy,
    input  in_rdy, rf_rs1, rf_rs2, rf_we, rf_wa, rf_wd,
    input  out_vld, out_op1, out_op2, out_rd, out_rd_we, sb_pend
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, scoreboard stall, same-cycle writeback bypass and a
// single-entry valid/ready output register.
module operand_fetch #(
  parameter int unsigned REGS_PTR_W = 5,
  parameter int unsigned REGS_NUM   = 32,
  parameter int unsigned REG_SIZE   = 32
) (
  input logic              clk,
  input logic              rst_n,
  operand_fetch_if.slave   bus
);

  logic [REGS_NUM-1:0]   sb_pend_q, sb_pend_d;
  logic [REGS_NUM-1:0]   clr, set, eff;
  logic                  out_vld_q, out_vld_d;
  logic [REG_SIZE-1:0]   out_op1_q, out_op1_d;
  logic [REG_SIZE-1:0]   out_op2_q, out_op2_d;
  logic [REGS_PTR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_rd_we_q, out_rd_we_d;
  logic                  haz_rs1, haz_rs2, haz_waw, hazard;
  logic                  in_rdy, accept;
  logic [REG_SIZE-1:0]   op1, op2;

  // Zero pointer reads as 0; a writeback landing this cycle overrides the stale file value.
  function automatic logic [REG_SIZE-1:0] sel_op(input logic [REGS_PTR_W-1:0] ptr,
                                                 input logic [REG_SIZE-1:0]   rf_val,
                                                 input logic                  wb_hit,
                                                 input logic [REG_SIZE-1:0]   wb_val);
    if (ptr == '0) begin
      return '0;
    end else if (wb_hit) begin
      return wb_val;
    end
    return rf_val;
  endfunction

  always_comb begin
    clr = '0;
    if (bus.wb_vld) begin
      clr[bus.wb_rd] = 1'b1;
    end
    eff = sb_pend_q & ~clr;

    haz_rs1 = (bus.in_rs1 != '0) & eff[bus.in_rs1];
    haz_rs2 = (bus.in_rs2 != '0) & eff[bus.in_rs2];
    haz_waw = bus.in_rd_we & (bus.in_rd != '0) & eff[bus.in_rd];
    hazard  = haz_rs1 | haz_rs2 | haz_waw;

    in_rdy = (~out_vld_q | bus.out_rdy) & ~hazard;
    accept = bus.in_vld & in_rdy;

    op1 = sel_op(bus.in_rs1, bus.rf_rd1, clr[bus.in_rs1], bus.wb_data);
    op2 = sel_op(bus.in_rs2, bus.rf_rd2, clr[bus.in_rs2], bus.wb_data);

    set = '0;
    if (accept && bus.in_rd_we && (bus.in_rd != '0)) begin
      set[bus.in_rd] = 1'b1;
    end
    // Set is OR-ed after the clear so a same-cycle reissue keeps the register pending.
    sb_pend_d = eff | set;
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    if (accept) begin
      out_vld_d   = 1'b1;
      out_op1_d   = op1;
      out_op2_d   = op2;
      out_rd_d    = bus.in_rd;
      out_rd_we_d = bus.in_rd_we;
    end else if (bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_pend_q   <= '0;
      out_vld_q   <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else begin
      sb_pend_q   <= sb_pend_d;
      out_vld_q   <= out_vld_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
    end
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.rf_rs1    = bus.in_rs1;
  assign bus.rf_rs2    = bus.in_rs2;
  assign bus.rf_we     = bus.wb_vld & (bus.wb_rd != '0);
  assign bus.rf_wa     = bus.wb_rd;
  assign bus.rf_wd     = bus.wb_data;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_op1   = out_op1_q;
  assign bus.out_op2   = out_op2_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_rd_we = out_rd_we_q;
  assign bus.sb_pend   = sb_pend_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting between decode and execute: drives the register file read ports (rs1/rs2), returns operands, and forwards writeback results into the register file write port. A per-register scoreboard tracks destinations issued but not yet written back. Instructions reading or overwriting a pending register are stalled, except when the matching writeback lands in the same cycle, in which case that data is bypassed. Output is a single-entry valid/ready pipeline register.

## Interface
- REGS_PTR_W, 5, register pointer width in bits
- REGS_NUM, 32, number of architectural registers
- REG_SIZE, 32, register width in bits

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  1  decoded instruction valid
- in_rdy  out  1  stage can accept instruction
- in_rs1, in_rs2  in  REGS_PTR_W  source register pointers
- in_rd  in  REGS_PTR_W  destination register pointer
- in_rd_we  in  1  instruction writes in_rd
- rf_rs1, rf_rs2  out  REGS_PTR_W  register file read addresses
- rf_rd1, rf_rd2  in  REG_SIZE  register file read data (combinational)
- rf_we  out  1  register file write enable
- rf_wa  out  REGS_PTR_W  register file write address
- rf_wd  out  REG_SIZE  register file write data
- wb_vld  in  1  writeback valid
- wb_rd  in  REGS_PTR_W  writeback destination
- wb_data  in  REG_SIZE  writeback data
- out_vld  out  1  operands valid to execute
- out_rdy  in  1  execute accepts
- out_op1, out_op2  out  REG_SIZE  operand values
- out_rd  out  REGS_PTR_W  destination pointer
- out_rd_we  out  1  destination write flag
- sb_pend  out  REGS_NUM  scoreboard pending vector (bit r = register r pending)

## Operation
- Register 0 is hardwired zero: an operand read of pointer 0 returns 0, never pending, never set in the scoreboard. A writeback to 0 does not assert rf_we.
- Read path: rf_rs1=in_rs1, rf_rs2=in_rs2, combinational.
- Write path: rf_we = wb_vld & (wb_rd!=0); rf_wa=wb_rd; rf_wd=wb_data. Combinational pass-through; the register file samples at the next clock edge.
- Writeback clear: clr[r] = wb_vld & (wb_rd==r). Effective pending: eff[r] = sb_pend[r] & ~clr[r].
- Hazard: rs1 hazard if eff[in_rs1]; rs2 hazard if eff[in_rs2]; WAW hazard if in_rd_we & eff[in_rd]. Pointer 0 never hazards.
- in_rdy = (~out_vld | out_rdy) & ~hazard. in_rdy must not depend on in_vld.
- Operand select, per source s:
  - 0 if pointer is 0;
  - else wb_data if clr[pointer] (same-cycle bypass);
  - else rf_rdN.
- Accept = in_vld & in_rdy. On accept, the output register loads operands, in_rd and in_rd_we, and out_vld is set.
- If out_vld & out_rdy and there is no accept, out_vld clears. Output fields hold their values while out_vld & ~out_rdy.
- Scoreboard next state: sb_pend[r] <= (sb_pend[r] & ~clr[r]) | set[r], where set[r] = accept & in_rd_we & (in_rd==r) & (r!=0). Set wins over a same-cycle clear.
- A writeback to a non-pending register writes the register file and leaves the scoreboard unchanged.

## Timing
- Reset (async assert, rst_n low):
  - out_vld=0, out_op1=0, out_op2=0, out_rd=0, out_rd_we=0, sb_pend=0.
  - in_rdy is then 1 whenever there is no hazard, which is always true from reset.
- Reset mid-operation discards any held instruction and clears all pending bits.
- Latency: 1 cycle from accept to out_vld. Full throughput, one instruction per cycle, with no hazards and out_rdy=1.
- Bypass: a writeback in cycle N is visible to an instruction accepted in cycle N via wb_data, and via rf_rdN from cycle N+1.
- Backpressure: while out_vld & ~out_rdy, in_rdy=0 and all out_* fields are stable.
- sb_pend is registered and reflects state after the last clock edge.

## Test plan
- Reset, then issue rs1=3, rs2=4, rd=5 with the register file holding r3=0x11 and r4=0x22 → next cycle out_vld=1, op1=0x11, op2=0x22, out_rd=5; sb_pend[5]=1.
- With r5 pending, issue rs1=5 → in_rdy=0 for each cycle without writeback. Apply wb_vld, wb_rd=5, wb_data=0xABCD in cycle N → accept in N, op1=0xABCD next cycle, sb_pend[5]=0.
- Issue rd=7 while r7 is pending (WAW) → stalls. Same cycle as wb_rd=7 → accepted, and sb_pend[7] remains 1 (set wins).
- Issue rs1=0, rs2=0, rd=0 with in_rd_we=1, plus wb_rd=0 → op1=op2=0, rf_we=0, sb_pend unchanged.
- Hold out_rdy=0 for 3 cycles with out_vld=1 → in_rdy=0 and outputs stable. Raise out_rdy with in_vld=1 → back-to-back transfer, out_vld stays 1 with new data.
- Assert rst_n=0 mid-stream with out_vld=1 and sb_pend≠0 → out_vld=0 and sb_pend=0 immediately (async). First accept after release succeeds.
